// File: rtl/trace_event_monitor.sv
// Per-core l.nop event monitor for the packed STM trace bus: shadows one GPR per core
// and merges detected events into a shared FIFO. Optional macro: TRACE_EVENT_MONITOR_DROP_COUNT_EN.

`ifndef DEBUG_STM_PORTWIDTH
`define DEBUG_STM_PORTWIDTH    71
`define DEBUG_STM_ENABLE_LSB   0
`define DEBUG_STM_INSN_LSB     1
`define DEBUG_STM_WB_LSB       33
`define DEBUG_STM_WBREG_LSB    34
`define DEBUG_STM_WBDATA_LSB   39
`endif

module trace_event_monitor #(
  parameter int NUMCORES   = 16,
  parameter int WBREG_IDX  = 3,
  parameter int FIFO_DEPTH = 8,
  localparam int CORE_ID_WIDTH = (NUMCORES > 1) ? $clog2(NUMCORES) : 1
) (
  input  logic                                    clk,
  input  logic                                    rst_sys,
  input  logic [`DEBUG_STM_PORTWIDTH*NUMCORES-1:0] trace_stm,
  output logic                                    ev_valid,
  input  logic                                    ev_ready,
  output logic [CORE_ID_WIDTH-1:0]                ev_core,
  output logic [15:0]                             ev_code,
  output logic [31:0]                             ev_value,
  output logic [NUMCORES-1:0]                     exit_mask,
  output logic                                    all_exited,
  output logic [15:0]                             drop_count
);

  localparam int W  = `DEBUG_STM_PORTWIDTH;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [NUMCORES-1:0]      pend_valid;
  logic [15:0]              pend_code  [NUMCORES];
  logic [31:0]              pend_value [NUMCORES];
  logic [NUMCORES-1:0]      det;
  logic [NUMCORES-1:0]      drop;

  logic                     gnt_valid;
  logic [CORE_ID_WIDTH-1:0] gnt_idx;
  logic [CORE_ID_WIDTH-1:0] next_ptr;
  logic [CORE_ID_WIDTH-1:0] rr_ptr;

  logic [AW-1:0]            wr_ptr, rd_ptr;
  logic [AW:0]              count;
  logic                     fifo_full, push, pop;

  logic [CORE_ID_WIDTH-1:0] core_mem  [FIFO_DEPTH];
  logic [15:0]              code_mem  [FIFO_DEPTH];
  logic [31:0]              value_mem [FIFO_DEPTH];

  // Per-core decode, shadow register, pending slot and exit flag
  for (genvar g = 0; g < NUMCORES; g++) begin : g_core
    localparam int BASE = g * W;

    logic        en, wb, granted, pv, ex;
    logic [7:0]  opcode;
    logic [7:0]  insn_mid_unused;
    logic [15:0] kfield, pc;
    logic [4:0]  wbreg;
    logic [31:0] wbdata, shadow, pval;

    assign en              = trace_stm[BASE + `DEBUG_STM_ENABLE_LSB];
    assign kfield          = trace_stm[BASE + `DEBUG_STM_INSN_LSB      +: 16];
    assign insn_mid_unused = trace_stm[BASE + `DEBUG_STM_INSN_LSB + 16 +: 8];
    assign opcode          = trace_stm[BASE + `DEBUG_STM_INSN_LSB + 24 +: 8];
    assign wb              = trace_stm[BASE + `DEBUG_STM_WB_LSB];
    assign wbreg           = trace_stm[BASE + `DEBUG_STM_WBREG_LSB     +: 5];
    assign wbdata          = trace_stm[BASE + `DEBUG_STM_WBDATA_LSB    +: 32];

    assign det[g]  = en && (opcode == 8'h15) && (kfield != '0);
    assign granted = gnt_valid && (gnt_idx == CORE_ID_WIDTH'(g));
    assign drop[g] = det[g] && pv && !granted;

    // The slot captures the shadow before this cycle's writeback lands
    always_ff @(posedge clk or posedge rst_sys) begin
      if (rst_sys) begin
        shadow <= '0;
        pv     <= 1'b0;
        pc     <= '0;
        pval   <= '0;
        ex     <= 1'b0;
      end else begin
        if (en && wb && (wbreg == 5'(WBREG_IDX)))
          shadow <= wbdata;
        if (det[g] && (!pv || granted)) begin
          pv   <= 1'b1;
          pc   <= kfield;
          pval <= shadow;
        end else if (granted) begin
          pv <= 1'b0;
        end
        if (det[g] && (kfield == 16'h0001))
          ex <= 1'b1;
      end
    end

    assign pend_valid[g] = pv;
    assign pend_code[g]  = pc;
    assign pend_value[g] = pval;
    assign exit_mask[g]  = ex;
  end

  // Round-robin: rotate the request vector so the search always starts at rr_ptr
  logic [2*NUMCORES-1:0] pend_dbl;
  logic [NUMCORES-1:0]   pend_rot;
  logic                  arb_any;
  int unsigned           arb_off, gnt_sum, nxt_sum;

  assign pend_dbl = {pend_valid, pend_valid};
  assign pend_rot = NUMCORES'(pend_dbl >> rr_ptr);

  always_comb begin
    arb_any = 1'b0;
    arb_off = 0;
    for (int unsigned j = 0; j < NUMCORES; j++) begin
      if (!arb_any && pend_rot[j]) begin
        arb_any = 1'b1;
        arb_off = j;
      end
    end
    gnt_sum = int'(rr_ptr) + arb_off;
    if (gnt_sum >= NUMCORES)
      gnt_sum = gnt_sum - NUMCORES;
    nxt_sum = gnt_sum + 1;
    if (nxt_sum >= NUMCORES)
      nxt_sum = 0;
    gnt_idx   = CORE_ID_WIDTH'(gnt_sum);
    next_ptr  = CORE_ID_WIDTH'(nxt_sum);
    gnt_valid = arb_any && !fifo_full;
  end

  assign fifo_full = (count == (AW+1)'(FIFO_DEPTH));
  assign ev_valid  = (count != '0);
  assign push      = gnt_valid;
  assign pop       = ev_valid && ev_ready;

  always_ff @(posedge clk or posedge rst_sys) begin
    if (rst_sys) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rr_ptr     <= '0;
      all_exited <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (gnt_valid)
        rr_ptr <= next_ptr;
      all_exited <= &exit_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      core_mem[wr_ptr]  <= gnt_idx;
      code_mem[wr_ptr]  <= pend_code[gnt_idx];
      value_mem[wr_ptr] <= pend_value[gnt_idx];
    end
  end

  // Storage is not reset, so the head fields are forced to zero while empty
  assign ev_core  = ev_valid ? core_mem[rd_ptr]  : '0;
  assign ev_code  = ev_valid ? code_mem[rd_ptr]  : '0;
  assign ev_value = ev_valid ? value_mem[rd_ptr] : '0;

`ifdef TRACE_EVENT_MONITOR_DROP_COUNT_EN
  logic [16:0] drop_sum;
  assign drop_sum = {1'b0, drop_count} + 17'($countones(drop));

  always_ff @(posedge clk or posedge rst_sys) begin
    if (rst_sys)
      drop_count <= '0;
    else if (drop_sum[16])
      drop_count <= '1;
    else
      drop_count <= drop_sum[15:0];
  end
`else
  logic drop_unused;
  assign drop_unused = |drop;
  assign drop_count  = '0;
`endif

endmodule

// File: tb/tb_trace_event_monitor.sv
// Randomized and directed bench for trace_event_monitor against a queue-based reference model.

`ifndef DEBUG_STM_PORTWIDTH
`define DEBUG_STM_PORTWIDTH    71
`define DEBUG_STM_ENABLE_LSB   0
`define DEBUG_STM_INSN_LSB     1
`define DEBUG_STM_WB_LSB       33
`define DEBUG_STM_WBREG_LSB    34
`define DEBUG_STM_WBDATA_LSB   39
`endif

module tb_trace_event_monitor;
  localparam int N     = 16;
  localparam int WBIDX = 3;
  localparam int DEPTH = 8;
  localparam int W     = `DEBUG_STM_PORTWIDTH;
  localparam int CW    = 4;

  logic           clk = 1'b0;
  logic           rst_sys;
  logic [W*N-1:0] trace_stm;
  logic           ev_valid, ev_ready;
  logic [CW-1:0]  ev_core;
  logic [15:0]    ev_code;
  logic [31:0]    ev_value;
  logic [N-1:0]   exit_mask;
  logic           all_exited;
  logic [15:0]    drop_count;

  trace_event_monitor #(.NUMCORES(N), .WBREG_IDX(WBIDX), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_sys(rst_sys), .trace_stm(trace_stm),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_core(ev_core),
    .ev_code(ev_code), .ev_value(ev_value), .exit_mask(exit_mask),
    .all_exited(all_exited), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Per-core trace stimulus
  logic        t_en [N];
  logic [31:0] t_insn [N];
  logic        t_wb [N];
  logic [4:0]  t_wbreg [N];
  logic [31:0] t_wbdata [N];

  // Reference model
  typedef struct {
    int          core;
    logic [15:0] code;
    logic [31:0] value;
  } ev_t;

  ev_t         m_q[$];
  logic [31:0] m_shadow [N];
  bit          m_pend [N];
  logic [15:0] m_pcode [N];
  logic [31:0] m_pval [N];
  int          m_ptr;
  logic [N-1:0] m_exit;
  bit          m_all;
  int          m_drops;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] nop(input logic [15:0] k);
    return {8'h15, 8'h00, k};
  endfunction

  task automatic clear_trace();
    for (int i = 0; i < N; i++) begin
      t_en[i] = 1'b0; t_insn[i] = '0; t_wb[i] = 1'b0; t_wbreg[i] = '0; t_wbdata[i] = '0;
    end
  endtask

  task automatic drive_trace();
    logic [W*N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      v[i*W + `DEBUG_STM_ENABLE_LSB]       = t_en[i];
      v[i*W + `DEBUG_STM_INSN_LSB +: 32]   = t_insn[i];
      v[i*W + `DEBUG_STM_WB_LSB]           = t_wb[i];
      v[i*W + `DEBUG_STM_WBREG_LSB +: 5]   = t_wbreg[i];
      v[i*W + `DEBUG_STM_WBDATA_LSB +: 32] = t_wbdata[i];
    end
    trace_stm = v;
  endtask

  task automatic set_nop(input int c, input logic [15:0] k);
    t_en[c] = 1'b1; t_insn[c] = nop(k);
  endtask

  task automatic set_wb(input int c, input logic [4:0] r, input logic [31:0] d);
    t_en[c] = 1'b1; t_wb[c] = 1'b1; t_wbreg[c] = r; t_wbdata[c] = d;
  endtask

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < N; i++) begin
      m_shadow[i] = '0; m_pend[i] = 1'b0; m_pcode[i] = '0; m_pval[i] = '0;
    end
    m_ptr = 0; m_exit = '0; m_all = 1'b0; m_drops = 0;
  endtask

  // One clock edge of the behavioural model, using the inputs the DUT sampled
  task automatic model_step();
    bit           full;
    int           win;
    logic [N-1:0] old_exit;
    bit           det;
    full     = (m_q.size() >= DEPTH);
    old_exit = m_exit;
    win      = -1;
    if (m_q.size() > 0 && ev_ready)
      void'(m_q.pop_front());
    if (!full) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (win < 0 && m_pend[c]) win = c;
      end
    end
    if (win >= 0) begin
      m_q.push_back('{win, m_pcode[win], m_pval[win]});
      m_pend[win] = 1'b0;
      m_ptr = (win + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      det = t_en[i] && (t_insn[i][31:24] == 8'h15) && (t_insn[i][15:0] != 16'h0);
      if (det) begin
        if (!m_pend[i]) begin
          m_pend[i] = 1'b1; m_pcode[i] = t_insn[i][15:0]; m_pval[i] = m_shadow[i];
        end else if (m_drops < 65535) begin
          m_drops++;
        end
        if (t_insn[i][15:0] == 16'h0001) m_exit[i] = 1'b1;
      end
      if (t_en[i] && t_wb[i] && (t_wbreg[i] == 5'(WBIDX)))
        m_shadow[i] = t_wbdata[i];
    end
    m_all = &old_exit;
  endtask

  function automatic int exp_drops();
`ifdef TRACE_EVENT_MONITOR_DROP_COUNT_EN
    return m_drops;
`else
    return 0;
`endif
  endfunction

  task automatic compare_outputs();
    check("ev_valid", ev_valid, m_q.size() > 0);
    if (m_q.size() > 0) begin
      check("ev_core", ev_core, m_q[0].core);
      check("ev_code", ev_code, m_q[0].code);
      check("ev_value", ev_value, m_q[0].value);
    end
    check("exit_mask", exit_mask, m_exit);
    check("all_exited", all_exited, m_all);
    check("drop_count", drop_count, exp_drops());
  endtask

  // Called 1 time unit after a rising edge; leaves the bench at the same phase
  task automatic step();
    drive_trace();
    @(posedge clk);
    model_step();
    #1;
    compare_outputs();
    clear_trace();
  endtask

  task automatic reset_dut();
    clear_trace();
    drive_trace();
    #2 rst_sys = 1'b1;
    model_reset();
    @(posedge clk);
    #1 rst_sys = 1'b0;
    check("rst_valid", ev_valid, 0);
    check("rst_fields", {ev_core, ev_code, ev_value}, 0);
    check("rst_exit", {all_exited, exit_mask}, 0);
    check("rst_drops", drop_count, 0);
  endtask

  initial begin
    int n, rise, maxoff;
    int off [N];
    rst_sys  = 1'b1;
    ev_ready = 1'b0;
    clear_trace();
    drive_trace();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_sys = 1'b0;
    check("init_valid", ev_valid, 0);
    check("init_exit", exit_mask, 0);

    // Core 5 writes r3, then l.nop 0x1 two cycles later
    set_wb(5, 5'd3, 32'h0000_002A); step();
    step();
    set_nop(5, 16'h0001); step();
    check("t1_lat_n1", ev_valid, 0);
    step();
    check("t1_valid", ev_valid, 1);
    check("t1_core", ev_core, 5);
    check("t1_code", ev_code, 16'h0001);
    check("t1_value", ev_value, 32'h2A);
    check("t1_exit", exit_mask, 16'h0020);
    ev_ready = 1'b1;
    repeat (3) step();

    // All cores l.nop 0x2 together drain in core order
    reset_dut();
    ev_ready = 1'b1;
    for (int i = 0; i < N; i++) set_nop(i, 16'h0002);
    step();
    n = 0;
    for (int s = 0; s < N + 3; s++) begin
      if (ev_valid) begin
        check("t2_order", ev_core, n);
        n++;
      end
      step();
    end
    check("t2_count", n, N);
    check("t2_drops", drop_count, 0);

    // Overflow with a stalled consumer
    reset_dut();
    ev_ready = 1'b0;
    for (int s = 0; s < 12; s++) begin
      set_nop(0, 16'h0003); step();
    end
    repeat (2) step();
`ifdef TRACE_EVENT_MONITOR_DROP_COUNT_EN
    check("t3_drops", drop_count, 3);
`else
    check("t3_drops", drop_count, 0);
`endif
    ev_ready = 1'b1;
    n = 0;
    for (int s = 0; s < 15; s++) begin
      if (ev_valid) n++;
      step();
    end
    check("t3_drained", n, 9);

    // Non-shadowed register and l.nop 0 produce nothing
    reset_dut();
    ev_ready = 1'b1;
    set_wb(2, 5'd4, 32'h0000_0055); set_nop(2, 16'h0000); step();
    repeat (3) step();
    check("t4_no_event", ev_valid, 0);
    set_nop(2, 16'h0007); step(); step();
    check("t4_shadow0", ev_value, 0);
    set_wb(2, 5'd3, 32'h0000_1234); set_nop(2, 16'h0008); step(); step();
    check("t4_preupd", ev_value, 0);
    set_nop(2, 16'h0009); step(); step();
    check("t4_updated", ev_value, 32'h1234);
    repeat (2) step();

    // Staggered exits; all_exited follows the last one by a cycle
    reset_dut();
    ev_ready = 1'b1;
    maxoff = 0;
    for (int i = 0; i < N; i++) begin
      off[i] = $urandom_range(0, 9);
      if (off[i] > maxoff) maxoff = off[i];
    end
    rise = -1;
    for (int s = 0; s < 13; s++) begin
      for (int i = 0; i < N; i++) if (off[i] == s) set_nop(i, 16'h0001);
      step();
      if (rise < 0 && all_exited) rise = s;
    end
    check("t5_rise", rise, maxoff + 1);
    repeat (N) step();

    // Randomized traffic
    reset_dut();
    for (int s = 0; s < 800; s++) begin
      for (int i = 0; i < N; i++) begin
        t_en[i] = ($urandom_range(0, 99) < 35);
        if ($urandom_range(0, 9) < 6)
          t_insn[i] = nop(($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(1, 6)));
        else
          t_insn[i] = $urandom;
        t_wb[i]     = $urandom_range(0, 1);
        t_wbreg[i]  = ($urandom_range(0, 1) == 0) ? 5'(WBIDX) : 5'($urandom_range(0, 31));
        t_wbdata[i] = $urandom;
      end
      ev_ready = ($urandom_range(0, 99) < ((s / 200) % 2 == 0 ? 30 : 80));
      step();
    end

    // Reset with events queued
    reset_dut();
    ev_ready = 1'b0;
    set_nop(1, 16'h0010); set_nop(2, 16'h0011); set_nop(3, 16'h0012); step();
    repeat (4) step();
    check("t6_queued", m_q.size(), 3);
    #2 rst_sys = 1'b1;
    #1;
    check("t6_rst_valid", ev_valid, 0);
    check("t6_rst_exit", exit_mask, 0);
    model_reset();
    @(posedge clk);
    #1 rst_sys = 1'b0;
    ev_ready = 1'b1;
    for (int s = 0; s < 10; s++) begin
      step();
      check("t6_no_stale", ev_valid, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/trace_event_monitor.md
# trace_event_monitor

Parametrised per-core monitor for the packed STM trace bus of a multi-core OpTiMSoC system. It shadows one selectable general-purpose register per core from the writeback trace and decodes `l.nop K` simulation events. Every event is queued with its core ID and the shadowed register value into one shared, back-pressurable event stream. It sits beside `system_*_dm` in verification benches and debug-capable builds, and replaces the fixed one-checker-per-core arrangement.

## Interface
Parameters:
- `NUMCORES`, 16: number of cores packed on `trace_stm`; range 1..64.
- `WBREG_IDX`, 3: GPR index shadowed per core; range 0..31.
- `FIFO_DEPTH`, 8: event FIFO entries; power of two, at least 2.
- `CORE_ID_WIDTH`: localparam equal to max(1, $clog2(NUMCORES)).

Ports:
- `clk`, in, 1: the single clock.
- `rst_sys`, in, 1: reset, asynchronous and active-high.
- `trace_stm`, in, `DEBUG_STM_PORTWIDTH*NUMCORES`: core i occupies slice [(i+1)*W-1 : i*W]. Fields are decoded with the `DEBUG_STM_*` macros from dbg_config.vh.
- `ev_valid`, out, 1: an event is presented at the FIFO head.
- `ev_ready`, in, 1: the consumer accepts the head event.
- `ev_core`, out, `CORE_ID_WIDTH`: source core of the head event.
- `ev_code`, out, 16: K field (insn[15:0]) of the `l.nop`.
- `ev_value`, out, 32: shadowed register value of the source core at event time.
- `exit_mask`, out, NUMCORES: bit i is sticky-set once core i executes `l.nop 0x1`.
- `all_exited`, out, 1: registered AND of `exit_mask`.
- `drop_count`, out, 16: count of events lost to overflow (see Configuration).

## Operation
Per-core capture runs in parallel for all cores, every cycle. Let `en`, `insn`, `wb`, `wbreg` and `wbdata` be core i's decoded fields.
- Shadow update: when `en && wb && wbreg==WBREG_IDX`, `shadow[i] <= wbdata`.
- Event detect: `en && insn[31:24]==8'h15 && insn[15:0]!=0`. Plain `l.nop 0` is ignored.
- The event value is the shadow contents before this cycle's update.
- Each core has a one-entry pending slot holding {code, value}.
  - A detected event loads the slot if it is empty, or if it is being granted in the same cycle.
  - Otherwise the event is dropped.
- `exit_mask[i]` is set on a detected code 0x0001, whether or not that event is dropped.

Arbitration:
- A round-robin arbiter considers all full pending slots and grants at most one per cycle.
- A grant happens only when the FIFO is not full, using the registered count; there is no push-on-pop bypass.
- The priority pointer moves to winner+1 mod NUMCORES after each grant and holds when there is no grant.

FIFO:
- The granted slot is written at the FIFO tail and its pending bit is cleared.
- `ev_valid` = FIFO not empty.
- The head is popped when `ev_valid && ev_ready`.
- Simultaneous push and pop leaves the count unchanged.
- Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset (asynchronous, takes effect immediately): all shadows 0, pending slots empty, RR pointer 0, FIFO empty, `ev_valid`=0, `ev_core`/`ev_code`/`ev_value`=0, `exit_mask`=0, `all_exited`=0, `drop_count`=0.
- Latency, uncontended with the FIFO empty:
  - The trace event is sampled at edge N, which sets the pending slot.
  - The grant occurs in cycle N+1 and the FIFO write at edge N+1.
  - `ev_valid`=1 during cycle N+2.
- Throughput is one event per cycle into the FIFO and one out of it.
- Output fields are stable while `ev_valid && !ev_ready`.
- `all_exited` rises one cycle after the last `exit_mask` bit sets.
- Reset asserted mid-operation discards all queued and pending events; nothing is emitted after release until new trace events arrive.
- `en`=0 on a core ignores all of that core's other fields.

## Configuration
- `TRACE_EVENT_MONITOR_DROP_COUNT_EN`
  - Defined: `drop_count` increments by 1 per dropped event and saturates at 0xFFFF. If several cores drop in the same cycle, it increments by the number of drops, still saturating.
  - Undefined: `drop_count` is tied to 0 and the counter logic is not built.
- Event loss behaviour is identical in both cases.

## Test plan
- Reset, then core 5 writes r3=0x0000_002A, then 2 cycles later executes `l.nop 0x1`:
  - `ev_valid` rises at N+2 with core=5, code=0x0001, value=0x2A.
  - `exit_mask`=0x0020.
- All 16 cores execute `l.nop 0x2` in the same cycle, with `ev_ready`=1:
  - 16 events come out in order core 0..15, one per cycle.
  - `drop_count`=0.
- `ev_ready`=0 and core 0 issues `l.nop 0x3` every cycle for 12 cycles (FIFO_DEPTH=8):
  - 8 events are queued plus 1 pending; `drop_count`=3 with the macro defined, 0 without.
  - Releasing `ev_ready` drains 9 events.
- Core 2 writes r4 only, and executes `l.nop 0x0`:
  - No event is produced and the shadow stays 0.
  - Repeated with WBREG_IDX=4, the shadow updates but still no event.
- All cores execute `l.nop 0x1` across varied cycles: `all_exited` rises exactly one cycle after the last one.
- Assert `rst_sys` with 3 events queued:
  - `ev_valid`=0 immediately and `exit_mask`=0.
  - No stale events appear after release.
